// File: rtl/sr04_multi_ranger.sv
// sr04_multi_ranger
//   Round-robin ranging engine for CH HC-SR04 ultrasonic sensors. Fires one
//   trigger at a time, times the returned echo in 1 us ticks, converts the
//   echo width to centimetres (58 us per cm) and reports each channel's
//   distance plus a timeout flag. Supports a single sweep and continuous
//   auto-repeat.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset
//   start     1-cycle pulse, begins a sweep when idle
//   auto_en   restart the sweep after the last channel when high
//   echo      raw asynchronous echo inputs, one per channel
//   trig      trigger outputs, at most one bit high
//   distance  packed distances, channel k at [k*DIST_W +: DIST_W]
//   valid     1-cycle pulse when channel k's distance updates
//   err       per-channel timeout flag
//   busy      high whenever the engine is not idle
//   state     current FSM state code
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// TRIG  | trig[ch] high for TRIG_US ticks
// WAIT  | waiting for a true 0->1 edge on echo[ch], TIMEOUT_US limit
// MEAS  | counting cm while echo[ch] is high, TIMEOUT_US limit
// GAP   | quiet time of GAP_US ticks, then next channel / repeat / idle

module sr04_multi_ranger #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CH         = 2,
  parameter int DIST_W     = 9,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 60000,
  parameter int MAX_CM     = 400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic [CH-1:0]        echo,
  output logic [CH-1:0]        trig,
  output logic [CH*DIST_W-1:0] distance,
  output logic [CH-1:0]        valid,
  output logic [CH-1:0]        err,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int DIV     = CLK_HZ / 1_000_000;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam int TMR_A   = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
  localparam int TMR_MAX = (TMR_A > TRIG_US) ? TMR_A : TRIG_US;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LD  = DIV_W'(DIV - 1);
  localparam logic [TMR_W-1:0]  TRIG_LD = TMR_W'(TRIG_US);
  localparam logic [TMR_W-1:0]  TMO_LD  = TMR_W'(TIMEOUT_US);
  localparam logic [TMR_W-1:0]  GAP_LD  = TMR_W'(GAP_US);
  localparam logic [DIST_W-1:0] MAX_V   = DIST_W'(MAX_CM);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH - 1);
  localparam logic [5:0]        SUB_LD  = 6'd57;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DIST_W-1:0]   cm_q, cm_d;
  logic [5:0]          sub_q, sub_d;
  logic [CH*DIST_W-1:0] dist_q, dist_d;
  logic [CH-1:0]       err_q, err_d;
  logic [CH-1:0]       valid_q, valid_d;
  logic [CH-1:0]       sync1_q, sync1_d;
  logic [CH-1:0]       sync2_q, sync2_d;
  logic [CH-1:0]       prev_q, prev_d;

  logic tick;
  logic echo_rise;
  logic echo_fall;

  // Free-running 1 us timebase: tick fires whenever the divider reaches 0.
  always_comb begin
    tick  = (div_q == '0);
    div_d = tick ? DIV_LD : div_q - 1'b1;
  end

  // Two-flop synchroniser plus one more stage to compare against for edges.
  always_comb begin
    sync1_d   = echo;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    echo_rise = sync2_q[ch_q] & ~prev_q[ch_q];
    echo_fall = ~sync2_q[ch_q] & prev_q[ch_q];
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    timer_d = timer_q;
    cm_d    = cm_q;
    sub_d   = sub_q;
    dist_d  = dist_q;
    err_d   = err_q;
    valid_d = '0;

    // The down-counter idles at zero; each state treats zero as terminal count.
    if (state_q != S_IDLE && tick && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRIG;
          ch_d    = '0;
          timer_d = TRIG_LD;
        end
      end

      S_TRIG: begin
        if (timer_q == '0) begin
          state_d = S_WAIT;
          timer_d = TMO_LD;
        end
      end

      S_WAIT: begin
        if (echo_rise) begin
          state_d = S_MEAS;
          timer_d = TMO_LD;
          cm_d    = '0;
          sub_d   = SUB_LD;
        end else if (timer_q == '0) begin
          err_d[ch_q] = 1'b1;
          state_d     = S_GAP;
          timer_d     = GAP_LD;
        end
      end

      S_MEAS: begin
        // 58 ticks per centimetre, saturating at MAX_CM.
        if (tick) begin
          if (sub_q == '0) begin
            sub_d = SUB_LD;
            if (cm_q != MAX_V) begin
              cm_d = cm_q + 1'b1;
            end
          end else begin
            sub_d = sub_q - 1'b1;
          end
        end
        if (echo_fall) begin
          dist_d[int'(ch_q)*DIST_W +: DIST_W] = cm_q;
          valid_d[ch_q] = 1'b1;
          err_d[ch_q]   = 1'b0;
          state_d       = S_GAP;
          timer_d       = GAP_LD;
        end else if (timer_q == '0) begin
          err_d[ch_q] = 1'b1;
          state_d     = S_GAP;
          timer_d     = GAP_LD;
        end
      end

      S_GAP: begin
        if (timer_q == '0) begin
          if (ch_q != LAST_CH) begin
            ch_d    = ch_q + 1'b1;
            state_d = S_TRIG;
            timer_d = TRIG_LD;
          end else if (auto_en) begin
            ch_d    = '0;
            state_d = S_TRIG;
            timer_d = TRIG_LD;
          end else begin
            ch_d    = '0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      div_q   <= '0;
      timer_q <= '0;
      cm_q    <= '0;
      sub_q   <= '0;
      dist_q  <= '0;
      err_q   <= '0;
      valid_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      cm_q    <= cm_d;
      sub_q   <= sub_d;
      dist_q  <= dist_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // trig decodes straight from the state register so a reset drops it on
  // the same edge that returns the FSM to IDLE.
  always_comb begin
    trig = '0;
    if (state_q == S_TRIG) begin
      trig[ch_q] = 1'b1;
    end
  end

  assign distance = dist_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_sr04_multi_ranger.sv
// Testbench for sr04_multi_ranger with a shortened timebase: 2 clk per us,
// short timeout/gap and a low saturation limit so every scenario fits in a
// short run. Sensors are modelled as processes that answer a trigger fall
// with an echo pulse of a programmed width.
module tb_sr04_multi_ranger;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int CH         = 2;
  localparam int DIST_W     = 9;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 2000;
  localparam int GAP_US     = 200;
  localparam int MAX_CM     = 30;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 auto_en;
  wire  [CH-1:0]        echo;
  logic [CH-1:0]        trig;
  logic [CH*DIST_W-1:0] distance;
  logic [CH-1:0]        valid;
  logic [CH-1:0]        err;
  logic                 busy;
  logic [2:0]           state;

  logic [CH-1:0] ovr;
  int            resp_w[CH];
  int            resp_dly;

  int checks = 0;
  int errors = 0;

  sr04_multi_ranger #(
    .CLK_HZ(CLK_HZ), .CH(CH), .DIST_W(DIST_W), .TRIG_US(TRIG_US),
    .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US), .MAX_CM(MAX_CM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .echo(echo),
    .trig(trig), .distance(distance), .valid(valid), .err(err),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Sensor model: after the trigger falls, wait resp_dly clk, then hold echo
  // high for resp_w us. resp_w == 0 means the sensor never answers.
  for (genvar k = 0; k < CH; k++) begin : g_sensor
    logic e = 1'b0;
    always begin
      @(negedge trig[k]);
      if (resp_w[k] > 0) begin
        repeat (resp_dly) @(posedge clk);
        #1 e = 1'b1;
        repeat (resp_w[k] * DIV) @(posedge clk);
        #1 e = 1'b0;
      end
    end
    assign echo[k] = e | ovr[k];
  end

  // Passive monitor, sampled on the falling edge.
  int            cyc = 0;
  int            valid_cnt[CH];
  int            trig_w_last[CH];
  int            trig_fall_cyc[CH];
  int            trig_t0[CH];
  int            rise_cyc[$];
  int            rise_ch[$];
  int            onehot_viol = 0;
  int            other_viol = 0;
  int            act_ch = 0;
  logic [CH-1:0] trig_prev = '0;
  logic [CH-1:0] err_prev = '0;
  logic [CH*DIST_W-1:0] dist_prev = '0;
  logic          rst_prev = 1'b0;

  initial begin
    for (int k = 0; k < CH; k++) begin
      valid_cnt[k] = 0; trig_w_last[k] = 0; trig_fall_cyc[k] = 0; trig_t0[k] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if ($countones(trig) > 1) onehot_viol++;
    for (int k = 0; k < CH; k++) begin
      if (valid[k] === 1'b1) valid_cnt[k]++;
      if (trig[k] && !trig_prev[k]) begin
        rise_cyc.push_back(cyc);
        rise_ch.push_back(k);
        trig_t0[k] = cyc;
        act_ch = k;
      end
      if (!trig[k] && trig_prev[k]) begin
        trig_w_last[k]   = cyc - trig_t0[k];
        trig_fall_cyc[k] = cyc;
      end
      if (rst && rst_prev && k != act_ch &&
          (distance[k*DIST_W +: DIST_W] != dist_prev[k*DIST_W +: DIST_W] ||
           err[k] != err_prev[k]))
        other_viol++;
    end
    trig_prev = trig;
    err_prev  = err;
    dist_prev = distance;
    rst_prev  = rst;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  function automatic int dist_of(input int k);
    return int'(distance[k*DIST_W +: DIST_W]);
  endfunction

  // Reference: floor(width_us / 58), saturated, with +-1 cm tick-phase slack.
  task automatic chk_dist(input string tag, input int k, input int w_us);
    int raw, lo, hi;
    raw = w_us / 58;
    lo  = (raw > 0) ? raw - 1 : 0;
    hi  = raw + 1;
    if (lo > MAX_CM) lo = MAX_CM;
    if (hi > MAX_CM) hi = MAX_CM;
    chk_rng(tag, dist_of(k), lo, hi);
  endtask

  task automatic sweep(input string tag, input int w0, input int w1);
    int v0, v1;
    v0 = valid_cnt[0];
    v1 = valid_cnt[1];
    resp_w[0] = w0;
    resp_w[1] = w1;
    pulse_start();
    wait_state(3'd0, 20000, {tag, "_idle"});
    step(2);
    chk_dist({tag, "_d0"}, 0, w0);
    chk_dist({tag, "_d1"}, 1, w1);
    chk({tag, "_err"}, err, 2'b00);
    chk({tag, "_v0"}, valid_cnt[0] - v0, 1);
    chk({tag, "_v1"}, valid_cnt[1] - v1, 1);
  endtask

  initial begin
    int v0, v1, d0_old, d1_old, n, base, viol, w0, w1;
    rst = 1'b0; start = 1'b0; auto_en = 1'b0; ovr = '0;
    resp_w[0] = 0; resp_w[1] = 0; resp_dly = 20;
    step(5);
    chk("rst_trig", trig, 0);
    chk("rst_dist", distance, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    rst = 1'b1;
    step(10);
    chk("idle_hold", state, 0);

    // Basic two-channel sweep.
    resp_w[0] = 580; resp_w[1] = 1160;
    v0 = valid_cnt[0]; v1 = valid_cnt[1];
    pulse_start();
    chk("basic_state_trig", state, 1);
    chk("basic_trig0", trig, 2'b01);
    chk("basic_busy", busy, 1);
    wait_state(3'd0, 20000, "basic_idle");
    step(2);
    chk_rng("basic_trig_w", trig_w_last[0], TRIG_US*DIV - DIV, TRIG_US*DIV + DIV);
    chk_dist("basic_d0", 0, 580);
    chk_dist("basic_d1", 1, 1160);
    chk("basic_err", err, 2'b00);
    chk("basic_v0", valid_cnt[0] - v0, 1);
    chk("basic_v1", valid_cnt[1] - v1, 1);
    chk("basic_busy_end", busy, 0);

    // Saturation: 1950 us is above MAX_CM*58 but below the timeout.
    sweep("sat", 1950, 300);
    chk("sat_exact", dist_of(0), MAX_CM);

    // Timeout on channel 1 while WAIT: error about TIMEOUT_US after trig1 falls.
    d1_old = dist_of(1);
    v1 = valid_cnt[1];
    resp_w[0] = 200; resp_w[1] = 0;
    pulse_start();
    n = 0;
    while (err[1] !== 1'b1 && n < 30000) begin step(1); n++; end
    chk("tmo_err_set", err[1], 1);
    chk_rng("tmo_delay", cyc - trig_fall_cyc[1], TIMEOUT_US*DIV - 10, TIMEOUT_US*DIV + 12);
    wait_state(3'd0, 20000, "tmo_idle");
    step(2);
    chk("tmo_dist_kept", dist_of(1), d1_old);
    chk("tmo_no_valid", valid_cnt[1] - v1, 0);
    chk("tmo_err_vec", err, 2'b10);
    sweep("recover", 580, 580);

    // Echo already high on WAIT entry is not an edge; off-channel echo ignored.
    d0_old = dist_of(0);
    v0 = valid_cnt[0];
    resp_w[0] = 0; resp_w[1] = 580;
    ovr[0] = 1'b1;
    pulse_start();
    wait_state(3'd2, 1000, "hi_wait");
    step(50);
    ovr[1] = 1'b1;
    step(200);
    ovr[1] = 1'b0;
    wait_state(3'd4, 10000, "hi_gap");
    chk("hi_err0", err[0], 1);
    ovr[0] = 1'b0;
    wait_state(3'd0, 20000, "hi_idle");
    step(2);
    chk("hi_no_valid0", valid_cnt[0] - v0, 0);
    chk("hi_dist0_kept", dist_of(0), d0_old);
    chk_dist("hi_d1", 1, 580);
    chk("hi_err_vec", err, 2'b01);

    // start during MEAS is ignored.
    base = rise_ch.size();
    v0 = valid_cnt[0];
    resp_w[0] = 1160; resp_w[1] = 100;
    pulse_start();
    wait_state(3'd3, 2000, "busy_meas");
    step(100);
    pulse_start();
    chk("busy_still_meas", state, 3);
    wait_state(3'd0, 20000, "busy_idle");
    step(2);
    chk_dist("busy_d0", 0, 1160);
    chk("busy_v0", valid_cnt[0] - v0, 1);
    chk("busy_trig_count", rise_ch.size() - base, 2);

    // Randomised sweeps against the arithmetic model.
    for (int r = 0; r < 3; r++) begin
      w0 = int'($urandom_range(1500, 60));
      w1 = int'($urandom_range(1500, 60));
      resp_dly = int'($urandom_range(60, 5));
      sweep($sformatf("rnd%0d", r), w0, w1);
    end
    resp_dly = 20;

    // Auto-repeat, dropped during channel 0 of the second sweep.
    resp_w[0] = 116; resp_w[1] = 116;
    base = rise_ch.size();
    auto_en = 1'b1;
    pulse_start();
    n = 0;
    while (rise_ch.size() < base + 3 && n < 20000) begin step(1); n++; end
    chk("auto_third_trig", rise_ch.size() >= base + 3, 1);
    auto_en = 1'b0;
    wait_state(3'd0, 20000, "auto_idle");
    step(50);
    chk("auto_trig_count", rise_ch.size() - base, 4);
    viol = 0;
    for (int i = 0; i < 4 && base + i < rise_ch.size(); i++) begin
      chk($sformatf("auto_seq%0d", i), rise_ch[base+i], i % 2);
      if (i > 0 && rise_cyc[base+i] - rise_cyc[base+i-1] < GAP_US*DIV) viol++;
    end
    chk("auto_gap_viol", viol, 0);

    // Reset during TRIG.
    resp_w[0] = 0; resp_w[1] = 0;
    pulse_start();
    step(3);
    chk("rtrig_in_trig", state, 1);
    rst = 1'b0;
    step(1);
    chk("rtrig_trig", trig, 0);
    chk("rtrig_dist", distance, 0);
    chk("rtrig_err", err, 0);
    chk("rtrig_busy", busy, 0);
    chk("rtrig_state", state, 0);
    rst = 1'b1;
    step(5);

    // Reset during MEAS.
    resp_w[0] = 1160;
    pulse_start();
    wait_state(3'd3, 2000, "rmeas_in_meas");
    step(20);
    rst = 1'b0;
    step(1);
    chk("rmeas_trig", trig, 0);
    chk("rmeas_valid", valid, 0);
    chk("rmeas_err", err, 0);
    chk("rmeas_busy", busy, 0);
    chk("rmeas_state", state, 0);
    rst = 1'b1;
    n = 0;
    while (echo !== '0 && n < 5000) begin step(1); n++; end
    chk("rmeas_echo_low", echo, 0);
    step(10);
    sweep("post_rst", 580, 1160);

    chk("onehot_trig", onehot_viol, 0);
    chk("other_ch_stable", other_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
